// File: rtl/kb_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Register map, STATUS bit positions, FSM states and frame helper.
package kb_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ACKERR  = 2;
    localparam int ST_TIMEOUT = 3;
    localparam int ST_OVR     = 4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        WAIT_IDLE
    } state_t;

    // Wire order after the start bit: d0..d7, odd parity, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/kb_tx_if.sv
// Wishbone slave bundle for the PS/2 transmitter.
// Master drives the cycle, slave answers with ack and read data.
interface kb_tx_if;

    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );

endinterface

// File: rtl/kb_tx_sync.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge pulse.
// Flops reset high so a released line never looks like an edge.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic s1;
    logic s2;
    logic prev;

    // Bring the line into the clock domain and keep one cycle history
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= line_i;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level_o = s2;
    assign fall_o  = prev & ~s2;

endmodule

// File: rtl/kb_tx.sv
// PS/2 host-to-device transmitter with a Wishbone register front end.
// Inhibit, request-to-send, 8 data bits, odd parity, stop, ack check.
module kb_tx
    import kb_tx_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic   clk_i,
    input  logic   rst_i,
    kb_tx_if.slave wb,
    output logic   int_o,
    output logic   busy_o,
    input  logic   kb_clk_i,
    input  logic   kb_dat_i,
    output logic   kb_clk_oe_o,
    output logic   kb_dat_oe_o
);

    localparam int INH_CYC = CLOCK_FREQ / 1000000 * INHIBIT_US;
    localparam int TO_CYC  = CLOCK_FREQ / 1000 * TIMEOUT_MS;
    localparam int MAX_CYC = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bitcnt;
    logic [7:0]       txdata;
    logic [4:1]       sticky;
    logic [4:1]       sticky_nxt;
    logic             ie;
    logic             ack_q;
    logic [31:0]      rdata;
    logic [9:0]       frame;

    logic sclk;
    logic sclk_fall;
    logic sdat;
    logic unused_dat_fall;
    logic unused_bits;

    ps2_line_sync u_clk_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .line_i  (kb_clk_i),
        .level_o (sclk),
        .fall_o  (sclk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .line_i  (kb_dat_i),
        .level_o (sdat),
        .fall_o  (unused_dat_fall)
    );

    assign unused_bits = &{1'b0, wb.adr_i[31:4], wb.adr_i[1:0],
                           wb.dat_i[31:8], wb.sel_i[3:1],
                           unused_dat_fall};

    logic bus_req;
    logic wr;
    logic wr_tx;
    logic wr_st;
    logic wr_ctrl;
    logic start;
    logic ovr_set;
    logic tmo;
    logic ack_edge;
    logic fin;

    assign bus_req = wb.cyc_i & wb.stb_i;
    assign wr      = ack_q & bus_req & wb.we_i & wb.sel_i[0];
    assign wr_tx   = wr & (wb.adr_i[3:2] == REG_TXDATA);
    assign wr_st   = wr & (wb.adr_i[3:2] == REG_STATUS);
    assign wr_ctrl = wr & (wb.adr_i[3:2] == REG_CTRL);
    assign start   = wr_tx & (state == IDLE);
    assign ovr_set = wr_tx & (state != IDLE);

    assign tmo = ((state == REQ) || (state == DATA) ||
                  (state == WAIT_IDLE)) && (cnt == TO_LAST);
    assign ack_edge = (state == DATA) && sclk_fall &&
                      (bitcnt == 4'd10) && !tmo;
    assign fin = (state == WAIT_IDLE) && sclk && sdat && !tmo;

    assign frame  = frame_bits(txdata);
    assign busy_o = (state != IDLE);

    // Frame sequencer: drives the open-drain enables from registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            kb_clk_oe_o <= 1'b0;
            kb_dat_oe_o <= 1'b0;
        end else if (tmo) begin
            state       <= IDLE;
            kb_clk_oe_o <= 1'b0;
            kb_dat_oe_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= INHIBIT;
                        cnt         <= '0;
                        kb_clk_oe_o <= 1'b1;
                        kb_dat_oe_o <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        state       <= REQ;
                        cnt         <= '0;
                        kb_clk_oe_o <= 1'b0;
                        kb_dat_oe_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sclk_fall) begin
                        state       <= DATA;
                        bitcnt      <= 4'd1;
                        kb_dat_oe_o <= ~frame[0];
                    end
                end
                DATA: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sclk_fall) begin
                        if (bitcnt == 4'd10) begin
                            state       <= WAIT_IDLE;
                            kb_dat_oe_o <= 1'b0;
                        end else begin
                            kb_dat_oe_o <= ~frame[bitcnt];
                            bitcnt      <= bitcnt + 4'd1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sclk && sdat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky status: clears apply first so hardware sets win
    always_comb begin
        sticky_nxt = sticky;
        if (wr_st) begin
            sticky_nxt = sticky_nxt & ~wb.dat_i[4:1];
        end
        if (start) begin
            sticky_nxt[ST_TIMEOUT:ST_DONE] = '0;
        end
        if (fin || tmo) begin
            sticky_nxt[ST_DONE] = 1'b1;
        end
        if (ack_edge && sdat) begin
            sticky_nxt[ST_ACKERR] = 1'b1;
        end
        if (tmo) begin
            sticky_nxt[ST_TIMEOUT] = 1'b1;
        end
        if (ovr_set) begin
            sticky_nxt[ST_OVR] = 1'b1;
        end
    end

    // Bus ack, register updates and the registered interrupt
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q  <= 1'b0;
            txdata <= '0;
            sticky <= '0;
            ie     <= 1'b0;
            int_o  <= 1'b0;
        end else begin
            ack_q  <= bus_req & ~ack_q;
            sticky <= sticky_nxt;
            int_o  <= ie & (|sticky);
            if (start) begin
                txdata <= wb.dat_i[7:0];
            end
            if (wr_ctrl) begin
                ie <= wb.dat_i[0];
            end
        end
    end

    // Read mux, only presented while ack is high
    always_comb begin
        rdata = '0;
        unique case (wb.adr_i[3:2])
            REG_TXDATA: rdata[7:0] = txdata;
            REG_STATUS: rdata[4:0] = {sticky, busy_o};
            REG_CTRL:   rdata[0]   = ie;
            default:    rdata      = '0;
        endcase
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = ack_q ? rdata : 32'd0;

endmodule
